// File: rtl/hazard_scoreboard.sv
// Load-use hazard scoreboard: tracks destination tags through ID/EX, EX/MEM and MEM/WB,
// publishes them to the forwarding unit and requests a one-cycle stall on load-use.
module hazard_scoreboard #(
   parameter int REG_W = 5,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_uses_rt,
   input  logic [REG_W-1:0] id_dest,
   input  logic             id_regwrite,
   input  logic             id_memread,
   input  logic             flush_ex,
   input  logic             hold,
   output logic [REG_W-1:0] ID_EX_RS,
   output logic [REG_W-1:0] ID_EX_RT,
   output logic [REG_W-1:0] EX_MEM_RD,
   output logic [REG_W-1:0] MEM_WB_RD,
   output logic             EX_MEM_REGWRITE,
   output logic             MEM_WB_REGWRITE,
   output logic             stall,
   output logic [CNT_W-1:0] stall_count
);

   logic             idex_valid_q, idex_valid_d;
   logic [REG_W-1:0] idex_rs_q, idex_rs_d;
   logic [REG_W-1:0] idex_rt_q, idex_rt_d;
   logic [REG_W-1:0] idex_dest_q, idex_dest_d;
   logic             idex_regwrite_q, idex_regwrite_d;
   logic             idex_memread_q, idex_memread_d;
   logic             exmem_valid_q, exmem_valid_d;
   logic [REG_W-1:0] exmem_dest_q, exmem_dest_d;
   logic             exmem_regwrite_q, exmem_regwrite_d;
   logic             memwb_valid_q, memwb_valid_d;
   logic [REG_W-1:0] memwb_dest_q, memwb_dest_d;
   logic             memwb_regwrite_q, memwb_regwrite_d;
   logic [CNT_W-1:0] stall_count_q, stall_count_d;
   logic             stall_w;

   // A load in EX whose result a valid ID instruction needs cannot be forwarded in time.
   always_comb begin
      stall_w = id_valid & idex_valid_q & idex_memread_q & idex_regwrite_q
              & (idex_dest_q != '0)
              & ((idex_dest_q == id_rs) | (id_uses_rt & (idex_dest_q == id_rt)))
              & ~flush_ex & ~hold;
   end

   always_comb begin
      idex_valid_d     = idex_valid_q;
      idex_rs_d        = idex_rs_q;
      idex_rt_d        = idex_rt_q;
      idex_dest_d      = idex_dest_q;
      idex_regwrite_d  = idex_regwrite_q;
      idex_memread_d   = idex_memread_q;
      exmem_valid_d    = exmem_valid_q;
      exmem_dest_d     = exmem_dest_q;
      exmem_regwrite_d = exmem_regwrite_q;
      memwb_valid_d    = memwb_valid_q;
      memwb_dest_d     = memwb_dest_q;
      memwb_regwrite_d = memwb_regwrite_q;
      stall_count_d    = stall_count_q;
      if (!hold) begin
         exmem_valid_d    = idex_valid_q;
         exmem_dest_d     = idex_dest_q;
         exmem_regwrite_d = idex_regwrite_q;
         memwb_valid_d    = exmem_valid_q;
         memwb_dest_d     = exmem_dest_q;
         memwb_regwrite_d = exmem_regwrite_q;
         // Flush, stall and an invalid ID slot all insert an all-zero bubble.
         if (flush_ex || stall_w || !id_valid) begin
            idex_valid_d    = 1'b0;
            idex_rs_d       = '0;
            idex_rt_d       = '0;
            idex_dest_d     = '0;
            idex_regwrite_d = 1'b0;
            idex_memread_d  = 1'b0;
         end else begin
            idex_valid_d    = 1'b1;
            idex_rs_d       = id_rs;
            idex_rt_d       = id_rt;
            idex_dest_d     = id_dest;
            idex_regwrite_d = id_regwrite;
            idex_memread_d  = id_memread;
         end
         if (stall_w && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idex_valid_q     <= 1'b0;
         idex_rs_q        <= '0;
         idex_rt_q        <= '0;
         idex_dest_q      <= '0;
         idex_regwrite_q  <= 1'b0;
         idex_memread_q   <= 1'b0;
         exmem_valid_q    <= 1'b0;
         exmem_dest_q     <= '0;
         exmem_regwrite_q <= 1'b0;
         memwb_valid_q    <= 1'b0;
         memwb_dest_q     <= '0;
         memwb_regwrite_q <= 1'b0;
         stall_count_q    <= '0;
      end else begin
         idex_valid_q     <= idex_valid_d;
         idex_rs_q        <= idex_rs_d;
         idex_rt_q        <= idex_rt_d;
         idex_dest_q      <= idex_dest_d;
         idex_regwrite_q  <= idex_regwrite_d;
         idex_memread_q   <= idex_memread_d;
         exmem_valid_q    <= exmem_valid_d;
         exmem_dest_q     <= exmem_dest_d;
         exmem_regwrite_q <= exmem_regwrite_d;
         memwb_valid_q    <= memwb_valid_d;
         memwb_dest_q     <= memwb_dest_d;
         memwb_regwrite_q <= memwb_regwrite_d;
         stall_count_q    <= stall_count_d;
      end
   end

   // Writes to $0 are never advertised to the forwarding unit.
   assign ID_EX_RS        = idex_rs_q;
   assign ID_EX_RT        = idex_rt_q;
   assign EX_MEM_RD       = exmem_dest_q;
   assign MEM_WB_RD       = memwb_dest_q;
   assign EX_MEM_REGWRITE = exmem_valid_q & exmem_regwrite_q & (exmem_dest_q != '0);
   assign MEM_WB_REGWRITE = memwb_valid_q & memwb_regwrite_q & (memwb_dest_q != '0);
   assign stall           = stall_w;
   assign stall_count     = stall_count_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: tag flow, load-use stall, flush and hold priority,
// asynchronous reset and counter saturation (second instance with a 2-bit counter).
module tb_hazard_scoreboard;

   logic       clk = 1'b0;
   logic       rst;
   logic       id_valid;
   logic [4:0] id_rs, id_rt, id_dest;
   logic       id_uses_rt, id_regwrite, id_memread;
   logic       flush_ex, hold;
   logic [4:0] ID_EX_RS, ID_EX_RT, EX_MEM_RD, MEM_WB_RD;
   logic       EX_MEM_REGWRITE, MEM_WB_REGWRITE, stall;
   logic [15:0] stall_count;
   logic [4:0] s_ID_EX_RS, s_ID_EX_RT, s_EX_MEM_RD, s_MEM_WB_RD;
   logic       s_EX_MEM_REGWRITE, s_MEM_WB_REGWRITE, s_stall;
   logic [1:0] s_stall_count;

   int checks = 0;
   int failures = 0;

   hazard_scoreboard #(.REG_W(5), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rt(id_uses_rt), .id_dest(id_dest), .id_regwrite(id_regwrite),
      .id_memread(id_memread), .flush_ex(flush_ex), .hold(hold),
      .ID_EX_RS(ID_EX_RS), .ID_EX_RT(ID_EX_RT), .EX_MEM_RD(EX_MEM_RD), .MEM_WB_RD(MEM_WB_RD),
      .EX_MEM_REGWRITE(EX_MEM_REGWRITE), .MEM_WB_REGWRITE(MEM_WB_REGWRITE),
      .stall(stall), .stall_count(stall_count)
   );

   hazard_scoreboard #(.REG_W(5), .CNT_W(2)) dut_sat (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rt(id_uses_rt), .id_dest(id_dest), .id_regwrite(id_regwrite),
      .id_memread(id_memread), .flush_ex(flush_ex), .hold(hold),
      .ID_EX_RS(s_ID_EX_RS), .ID_EX_RT(s_ID_EX_RT), .EX_MEM_RD(s_EX_MEM_RD), .MEM_WB_RD(s_MEM_WB_RD),
      .EX_MEM_REGWRITE(s_EX_MEM_REGWRITE), .MEM_WB_REGWRITE(s_MEM_WB_REGWRITE),
      .stall(s_stall), .stall_count(s_stall_count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drives one ID-stage instruction (valid, rs, rt, uses_rt, dest, regwrite, memread).
   task automatic applyStimulus(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                                input logic urt, input logic [4:0] dest, input logic rw,
                                input logic mr);
      id_valid    = v;
      id_rs       = rs;
      id_rt       = rt;
      id_uses_rt  = urt;
      id_dest     = dest;
      id_regwrite = rw;
      id_memread  = mr;
   endtask

   task automatic idle();
      applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   task automatic checkAll(input string tag, input logic [4:0] rs, input logic [4:0] rt,
                           input logic [4:0] exrd, input logic [4:0] wbrd, input logic exw,
                           input logic wbw, input logic st, input logic [15:0] cnt);
      checkOutput({tag, ".ID_EX_RS"}, 32'(ID_EX_RS), 32'(rs));
      checkOutput({tag, ".ID_EX_RT"}, 32'(ID_EX_RT), 32'(rt));
      checkOutput({tag, ".EX_MEM_RD"}, 32'(EX_MEM_RD), 32'(exrd));
      checkOutput({tag, ".MEM_WB_RD"}, 32'(MEM_WB_RD), 32'(wbrd));
      checkOutput({tag, ".EX_MEM_REGWRITE"}, 32'(EX_MEM_REGWRITE), 32'(exw));
      checkOutput({tag, ".MEM_WB_REGWRITE"}, 32'(MEM_WB_REGWRITE), 32'(wbw));
      checkOutput({tag, ".stall"}, 32'(stall), 32'(st));
      checkOutput({tag, ".stall_count"}, 32'(stall_count), 32'(cnt));
   endtask

   initial begin
      // Reset with random ID inputs
      rst = 1'b1;
      flush_ex = 1'b0;
      hold = 1'b0;
      applyStimulus(1'b1, 5'($urandom), 5'($urandom), 1'($urandom), 5'($urandom), 1'b1, 1'b1);
      #2;
      checkAll("reset", 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      tick();
      checkAll("reset_held", 0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("reset_sat_cnt", 32'(s_stall_count), 0);
      idle();
      rst = 1'b0;
      tick(); tick(); tick();
      checkAll("reset_idle", 0, 0, 0, 0, 0, 0, 0, 0);

      // Tag flow: add $5
      applyStimulus(1'b1, 5'd1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0);
      tick();
      idle();
      checkAll("tag_c1", 1, 2, 0, 0, 0, 0, 0, 0);
      tick();
      checkAll("tag_c2", 0, 0, 5, 0, 1, 0, 0, 0);
      tick();
      checkAll("tag_c3", 0, 0, 0, 5, 0, 1, 0, 0);

      // Dest 0 is never advertised
      applyStimulus(1'b1, 5'd3, 5'd4, 1'b1, 5'd0, 1'b1, 1'b0);
      tick();
      idle();
      tick();
      checkAll("dest0_c2", 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      checkAll("dest0_c3", 0, 0, 0, 0, 0, 0, 0, 0);

      // Load-use: lw $8 then add $9,$8,$3
      applyStimulus(1'b1, 5'd4, 5'd8, 1'b0, 5'd8, 1'b1, 1'b1);
      tick();
      applyStimulus(1'b1, 5'd8, 5'd3, 1'b1, 5'd9, 1'b1, 1'b0);
      #1;
      checkAll("lu_detect", 4, 8, 0, 0, 0, 0, 1, 0);
      tick();
      checkAll("lu_bubble", 0, 0, 8, 0, 1, 0, 0, 1);
      tick();
      idle();
      checkAll("lu_dep_in_ex", 8, 3, 0, 8, 0, 1, 0, 1);
      tick(); tick();

      // rt match ignored when the instruction does not read rt
      applyStimulus(1'b1, 5'd4, 5'd8, 1'b0, 5'd8, 1'b1, 1'b1);
      tick();
      applyStimulus(1'b1, 5'd1, 5'd8, 1'b0, 5'd9, 1'b1, 1'b0);
      #1;
      checkOutput("nort_stall", 32'(stall), 0);
      tick();
      idle();
      checkAll("nort_advance", 1, 8, 8, 0, 1, 0, 0, 1);
      tick(); tick(); tick();

      // Flush beats load-use
      applyStimulus(1'b1, 5'd4, 5'd8, 1'b0, 5'd8, 1'b1, 1'b1);
      tick();
      applyStimulus(1'b1, 5'd8, 5'd3, 1'b1, 5'd9, 1'b1, 1'b0);
      flush_ex = 1'b1;
      #1;
      checkOutput("flush_stall", 32'(stall), 0);
      tick();
      flush_ex = 1'b0;
      idle();
      checkAll("flush_bubble", 0, 0, 8, 0, 1, 0, 0, 1);
      tick(); tick(); tick();

      // Hold for 4 cycles with a pending load-use
      applyStimulus(1'b1, 5'd11, 5'd12, 1'b1, 5'd10, 1'b1, 1'b0);
      tick();
      applyStimulus(1'b1, 5'd14, 5'd15, 1'b0, 5'd13, 1'b1, 1'b1);
      tick();
      applyStimulus(1'b1, 5'd13, 5'd1, 1'b1, 5'd16, 1'b1, 1'b0);
      hold = 1'b1;
      #1;
      checkAll("hold_c0", 14, 15, 10, 0, 1, 0, 0, 1);
      for (int i = 0; i < 4; i++) begin
         tick();
         checkAll("hold_frozen", 14, 15, 10, 0, 1, 0, 0, 1);
      end
      hold = 1'b0;
      #1;
      checkOutput("hold_release_stall", 32'(stall), 1);
      tick();
      checkAll("hold_resume_c1", 0, 0, 13, 10, 1, 1, 0, 2);
      tick();
      idle();
      checkAll("hold_resume_c2", 13, 1, 0, 13, 0, 1, 0, 2);
      tick(); tick(); tick();

      // Asynchronous reset mid-stall
      applyStimulus(1'b1, 5'd4, 5'd8, 1'b0, 5'd8, 1'b1, 1'b1);
      tick();
      applyStimulus(1'b1, 5'd8, 5'd3, 1'b1, 5'd9, 1'b1, 1'b0);
      #1;
      checkOutput("rst_pre_stall", 32'(stall), 1);
      rst = 1'b1;
      #1;
      checkAll("rst_async", 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      idle();
      rst = 1'b0;
      tick();

      // Saturation: five load-use stalls into a 2-bit counter
      for (int i = 1; i <= 5; i++) begin
         applyStimulus(1'b1, 5'd4, 5'd8, 1'b0, 5'd8, 1'b1, 1'b1);
         tick();
         applyStimulus(1'b1, 5'd8, 5'd3, 1'b1, 5'd9, 1'b1, 1'b0);
         #1;
         checkOutput("sat_stall", 32'(s_stall), 1);
         tick();
         idle();
         checkOutput("sat_count", 32'(s_stall_count), (i > 3) ? 32'd3 : 32'(i));
         checkOutput("wide_count", 32'(stall_count), 32'(i));
         tick();
      end
      tick(); tick();
      checkOutput("sat_final", 32'(s_stall_count), 3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
